// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch run-control path: FSM states and count direction.
package stopwatch_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    RUNNING = 3'd1,
    LAP     = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/stopwatch_control_if.sv
// Signal bundle between the button/counter side and the stopwatch run-control block.
interface stopwatch_control_if;
  import stopwatch_pkg::*;

  // No valid/ready pairs: button and switch inputs are synchronous levels, tick and
  // counter_clear are single-cycle pulses, everything else is a registered level.
  logic               start_stop;
  logic               lap_reset;
  logic               count_down;
  logic               tick;
  logic               time_zero;
  logic               time_max;
  logic               count_enable;
  logic               up_down;
  logic               counter_clear;
  logic               display_hold;
  logic               alarm;
  logic               blink;
  logic [STATE_W-1:0] state;

  modport master (
    output start_stop, lap_reset, count_down, tick, time_zero, time_max,
    input  count_enable, up_down, counter_clear, display_hold, alarm, blink, state
  );

  modport slave (
    input  start_stop, lap_reset, count_down, tick, time_zero, time_max,
    output count_enable, up_down, counter_clear, display_hold, alarm, blink, state
  );

endinterface

// File: rtl/stopwatch_control_press_detect.sv
// Rising-edge press detector for a debounced button level.
module press_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic prev;

  // prev resets high so a button held through reset is not seen as a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b1;
    end else begin
      prev <= level;
    end
  end

  assign press = level & ~prev;

endmodule

// File: rtl/stopwatch_control.sv
// Run-control sequencer: buttons and direction switch to enable/direction/clear for the
// mm:ss BCD counter chain, plus lap hold and the DONE alarm/blink indication.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES = 50_000_000
) (
  input logic                clk,
  input logic                rst,
  stopwatch_control_if.slave bus
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  state_t           state_q;
  state_t           state_d;
  logic             clear_d;
  logic             up_down_q;
  logic             counter_clear_q;
  logic             display_hold_q;
  logic             alarm_q;
  logic             blink_q;
  logic [CNT_W-1:0] blink_cnt;

  logic start_press;
  logic lap_press_raw;
  logic lap_press;
  logic term;
  logic counting;

  press_detect u_start_press (
    .clk   (clk),
    .rst   (rst),
    .level (bus.start_stop),
    .press (start_press)
  );

  press_detect u_lap_press (
    .clk   (clk),
    .rst   (rst),
    .level (bus.lap_reset),
    .press (lap_press_raw)
  );

  // start_stop wins a same-cycle collision; the lap press is dropped
  assign lap_press = lap_press_raw & ~start_press;

  assign term     = (up_down_q == DIR_DOWN) ? bus.time_zero : bus.time_max;
  assign counting = (state_q == RUNNING) || (state_q == LAP);

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_press) begin
          if (!term) begin
            state_d = RUNNING;
          end
        end else if (lap_press) begin
          clear_d = 1'b1;
        end
      end
      RUNNING: begin
        if (term) begin
          state_d = DONE;
        end else if (start_press) begin
          state_d = PAUSED;
        end else if (lap_press) begin
          state_d = LAP;
        end
      end
      LAP: begin
        if (term) begin
          state_d = DONE;
        end else if (start_press) begin
          state_d = PAUSED;
        end else if (lap_press) begin
          state_d = RUNNING;
        end
      end
      PAUSED: begin
        if (start_press) begin
          state_d = RUNNING;
        end else if (lap_press) begin
          clear_d = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (start_press) begin
          state_d = IDLE;
        end else if (lap_press) begin
          clear_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Direction tracks the switch only while resting in IDLE; it freezes on the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      up_down_q       <= DIR_UP;
      counter_clear_q <= 1'b0;
      display_hold_q  <= 1'b0;
      alarm_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      counter_clear_q <= clear_d;
      display_hold_q  <= (state_d == LAP);
      alarm_q         <= (state_d == DONE);
      if ((state_q == IDLE) && (state_d == IDLE)) begin
        up_down_q <= bus.count_down;
      end
    end
  end

  // Counter restarts on DONE entry and is held clear outside DONE, so blink leaves at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if ((state_q != DONE) || (state_d != DONE)) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.count_enable  = counting & bus.tick & ~term;
  assign bus.up_down       = up_down_q;
  assign bus.counter_clear = counter_clear_q;
  assign bus.display_hold  = display_hold_q;
  assign bus.alarm         = alarm_q;
  assign bus.blink         = blink_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed and randomized bench for stopwatch_control with a behavioural reference model.
module tb_stopwatch_control;

  localparam int BC = 4;

  logic clk;
  logic rst;

  stopwatch_control_if bus ();

  stopwatch_control #(.BLINK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 idle, 1 running, 2 lap, 3 paused, 4 done
  int   m_mode;
  logic m_dir, m_clear, m_hold, m_alarm, m_blink;
  logic prev_ss, prev_lr;
  int   done_cycles;
  int   cnt;
  logic last_ce;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode      = 0;
    m_dir       = 1'b0;
    m_clear     = 1'b0;
    m_hold      = 1'b0;
    m_alarm     = 1'b0;
    m_blink     = 1'b0;
    prev_ss     = 1'b1;
    prev_lr     = 1'b1;
    done_cycles = 0;
    exp_q.delete();
    exp_q.push_back(3'd0);
  endtask

  // Drives one cycle of inputs, checks every output against the model, then clocks.
  task automatic cyc(input logic ss, input logic lr, input logic cd, input logic tk,
                     input logic tz, input logic tm);
    logic sp, lp, term, e_ce, clr;
    logic [2:0] e_st;
    int nxt;
    bus.start_stop = ss;
    bus.lap_reset  = lr;
    bus.count_down = cd;
    bus.tick       = tk;
    bus.time_zero  = tz;
    bus.time_max   = tm;
    #2;
    sp   = ss && !prev_ss;
    lp   = lr && !prev_lr && !sp;
    term = m_dir ? tz : tm;
    e_ce = ((m_mode == 1) || (m_mode == 2)) && tk && !term;
    last_ce = bus.count_enable;
    e_st = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7;
    check("state", 32'(bus.state), 32'(e_st));
    check("count_enable", 32'(bus.count_enable), 32'(e_ce));
    check("up_down", 32'(bus.up_down), 32'(m_dir));
    check("counter_clear", 32'(bus.counter_clear), 32'(m_clear));
    check("display_hold", 32'(bus.display_hold), 32'(m_hold));
    check("alarm", 32'(bus.alarm), 32'(m_alarm));
    check("blink", 32'(bus.blink), 32'(m_blink));

    nxt = m_mode;
    clr = 1'b0;
    if (m_mode == 0) begin
      if (sp && !term) nxt = 1;
      else if (!sp && lp) clr = 1'b1;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (term) nxt = 4;
      else if (sp) nxt = 3;
      else if (lp) nxt = (m_mode == 1) ? 2 : 1;
    end else if (m_mode == 3) begin
      if (sp) nxt = 1;
      else if (lp) begin clr = 1'b1; nxt = 0; end
    end else begin
      if (sp) nxt = 0;
      else if (lp) begin clr = 1'b1; nxt = 0; end
    end

    // the counter chain owned by the bench
    if (m_clear) cnt = 0;
    else if (e_ce) cnt = m_dir ? cnt - 1 : cnt + 1;

    if (nxt == 4 && m_mode != 4) done_cycles = 0;
    else if (nxt == 4) done_cycles++;
    m_blink = (nxt == 4) ? (((done_cycles / BC) % 2) == 1) : 1'b0;
    if (m_mode == 0 && nxt == 0) m_dir = cd;
    m_clear = clr;
    m_hold  = (nxt == 2);
    m_alarm = (nxt == 4);
    prev_ss = ss;
    prev_lr = lr;
    m_mode  = nxt;
    exp_q.push_back(3'(nxt));
    @(posedge clk);
    #1;
  endtask

  logic r_ss, r_lr, r_cd, n_ss, n_lr, tk;

  initial begin
    rst = 1'b1;
    bus.start_stop = 1'b1;
    bus.lap_reset  = 1'b0;
    bus.count_down = 1'b0;
    bus.tick       = 1'b0;
    bus.time_zero  = 1'b0;
    bus.time_max   = 1'b0;
    cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset values
    check("rst_state", 32'(bus.state), 0);
    check("rst_clear", 32'(bus.counter_clear), 0);
    check("rst_hold", 32'(bus.display_hold), 0);
    check("rst_alarm", 32'(bus.alarm), 0);
    check("rst_blink", 32'(bus.blink), 0);
    check("rst_up_down", 32'(bus.up_down), 0);

    // start_stop held high through reset release is not a press
    cyc(1, 0, 0, 0, 0, 0);
    check("held_no_press", 32'(bus.state), 0);
    cyc(0, 0, 0, 0, 0, 0);

    // basic run
    cyc(1, 0, 0, 0, 0, 0);
    check("run_state", 32'(bus.state), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      check("run_tick_ce", 32'(last_ce), 1);
      cyc(0, 0, 0, 0, 0, 0);
    end

    // pause
    cyc(1, 0, 0, 0, 0, 0);
    check("pause_state", 32'(bus.state), 3);
    cyc(0, 0, 0, 1, 0, 0);
    check("pause_tick_ce", 32'(last_ce), 0);

    // clear from pause
    cyc(0, 1, 0, 0, 0, 0);
    check("pause_clear", 32'(bus.counter_clear), 1);
    check("pause_clear_state", 32'(bus.state), 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("clear_one_cycle", 32'(bus.counter_clear), 0);

    // lap
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("lap_state", 32'(bus.state), 2);
    check("lap_hold", 32'(bus.display_hold), 1);
    cyc(0, 0, 0, 1, 0, 0);
    check("lap_tick1", 32'(last_ce), 1);
    cyc(0, 0, 0, 1, 0, 0);
    check("lap_tick2", 32'(last_ce), 1);
    cyc(0, 1, 0, 0, 0, 0);
    check("unlap_state", 32'(bus.state), 1);
    check("unlap_hold", 32'(bus.display_hold), 0);
    cyc(0, 0, 0, 0, 0, 0);

    // simultaneous presses in RUNNING: start wins
    cyc(1, 1, 0, 0, 0, 0);
    check("both_state", 32'(bus.state), 3);
    check("both_no_clear", 32'(bus.counter_clear), 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // countdown expiry
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("down_dir", 32'(bus.up_down), 1);
    cyc(1, 0, 1, 0, 0, 0);
    check("down_run", 32'(bus.state), 1);
    cyc(0, 0, 1, 1, 1, 0);
    check("expiry_tick_ce", 32'(last_ce), 0);
    check("done_state", 32'(bus.state), 4);
    check("done_alarm", 32'(bus.alarm), 1);
    check("blink_entry", 32'(bus.blink), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1, 0);
    check("blink_before", 32'(bus.blink), 0);
    cyc(0, 0, 1, 0, 1, 0);
    check("blink_first", 32'(bus.blink), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1, 0);
    check("blink_second", 32'(bus.blink), 0);
    cyc(1, 0, 1, 0, 1, 0);
    check("done_exit_state", 32'(bus.state), 0);
    check("done_exit_alarm", 32'(bus.alarm), 0);
    check("done_exit_noclr", 32'(bus.counter_clear), 0);
    cyc(0, 0, 1, 0, 1, 0);

    // start at 00:00 counting down stays in IDLE
    cyc(1, 0, 1, 0, 1, 0);
    check("zero_start_idle", 32'(bus.state), 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // async reset while in LAP
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("pre_reset_lap", 32'(bus.state), 2);
    #2;
    rst = 1'b1;
    #1;
    check("async_state", 32'(bus.state), 0);
    check("async_hold", 32'(bus.display_hold), 0);
    check("async_ce", 32'(bus.count_enable), 0);
    check("async_alarm", 32'(bus.alarm), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized phase against the model with a bench-owned counter chain
    cnt  = 0;
    r_ss = bus.start_stop;
    r_lr = bus.lap_reset;
    r_cd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      n_ss = ($urandom_range(0, 7) == 0) ? ~r_ss : r_ss;
      n_lr = ($urandom_range(0, 7) == 0) ? ~r_lr : r_lr;
      if (!(n_ss && !r_ss) && ($urandom_range(0, 15) == 0)) r_cd = ~r_cd;
      if (!m_clear && ($urandom_range(0, 99) == 0))
        cnt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(3595, 3599));
      tk = ($urandom_range(0, 2) == 0);
      cyc(n_ss, n_lr, r_cd, tk, cnt == 0, cnt == 3599);
      r_ss = n_ss;
      r_lr = n_lr;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
